// File: rtl/adc_timing_pkg.sv
// Shared timing definitions for the serial-ADC clock/chip-select generator and
// the ADC receive path: FSM states, counter width helpers and default constants.
package adc_timing_pkg;

  localparam int HALF_DIV_DEF   = 4;
  localparam int FRAME_BITS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  function automatic int prescale_w(input int half_div);
    return (half_div <= 2) ? 1 : $clog2(half_div);
  endfunction

  function automatic int gap_w(input int gap_bits);
    return $clog2(2 * gap_bits + 1);
  endfunction

  function automatic int bit_w(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/adc_sclk_cs_gen_if.sv
// Control and timing bundle between the generator and its controller/consumers.
interface adc_sclk_cs_gen_if
  import adc_timing_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF
);
  localparam int BW = bit_w(FRAME_BITS);

  logic          en;
  logic          cont;
  logic          trig;
  logic          sclk;
  logic          cs_n;
  logic          sclk_lead;
  logic          sclk_trail;
  logic [BW-1:0] bit_cnt;
  logic          frame_start;
  logic          frame_done;
  logic          busy;

  modport master (
    output en, cont, trig,
    input  sclk, cs_n, sclk_lead, sclk_trail, bit_cnt, frame_start, frame_done, busy
  );

  modport slave (
    input  en, cont, trig,
    output sclk, cs_n, sclk_lead, sclk_trail, bit_cnt, frame_start, frame_done, busy
  );

endinterface

// File: rtl/adc_sclk_cs_gen_tick_gen.sv
// Half-period prescaler: pulses tick every HALF_DIV cycles while run is high,
// and sits at zero while run is low so the first tick is always a full half-period away.
module tick_gen
  import adc_timing_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int PW = prescale_w(HALF_DIV);
  localparam logic [PW-1:0] LAST = PW'(HALF_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/adc_sclk_cs_gen.sv
// Serial-ADC timing master: divided sclk, active-low cs_n framing and single-cycle
// edge strobes, all registered in the system clock domain.
module adc_sclk_cs_gen
  import adc_timing_pkg::*;
#(
  parameter int HALF_DIV   = HALF_DIV_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int GAP_BITS   = 1,
  parameter bit CPOL       = 1'b1
) (
  input logic              clk,
  input logic              rst,
  adc_sclk_cs_gen_if.slave bus
);

  localparam int BW = bit_w(FRAME_BITS);
  localparam int GW = gap_w(GAP_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);
  localparam logic [GW-1:0] GAP_LAST = GW'(2 * GAP_BITS - 1);

  state_t        state, state_nxt;
  logic          sclk_q, sclk_nxt;
  logic          cs_n_q, cs_n_nxt;
  logic          lead_q, lead_nxt;
  logic          trail_q, trail_nxt;
  logic          fs_q, fs_nxt;
  logic          fd_q, fd_nxt;
  logic [BW-1:0] bit_q, bit_nxt, bit_inc;
  logic [GW-1:0] gap_q, gap_nxt;
  logic          tick;
  logic          start;

  tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state != IDLE),
    .tick (tick)
  );

  assign start   = bus.en && (bus.cont || bus.trig);
  assign bit_inc = bit_q + BW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sclk_q  <= CPOL;
      cs_n_q  <= 1'b1;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state   <= state_nxt;
      sclk_q  <= sclk_nxt;
      cs_n_q  <= cs_n_nxt;
      lead_q  <= lead_nxt;
      trail_q <= trail_nxt;
      fs_q    <= fs_nxt;
      fd_q    <= fd_nxt;
      bit_q   <= bit_nxt;
      gap_q   <= gap_nxt;
    end
  end

  // The frame closes on the same tick as its last trailing edge, and a gap that
  // ends on a tick leaves the prescaler at zero, so back-to-back frames need no idle cycle.
  always_comb begin
    state_nxt = state;
    sclk_nxt  = sclk_q;
    cs_n_nxt  = cs_n_q;
    lead_nxt  = 1'b0;
    trail_nxt = 1'b0;
    fs_nxt    = 1'b0;
    fd_nxt    = 1'b0;
    bit_nxt   = bit_q;
    gap_nxt   = gap_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACTIVE;
          cs_n_nxt  = 1'b0;
          fs_nxt    = 1'b1;
          bit_nxt   = '0;
        end
      end
      ACTIVE: begin
        if (tick) begin
          sclk_nxt = ~sclk_q;
          if (sclk_q == CPOL) begin
            lead_nxt = 1'b1;
          end else begin
            trail_nxt = 1'b1;
            bit_nxt   = bit_inc;
            if (bit_inc == BIT_LAST) begin
              cs_n_nxt  = 1'b1;
              fd_nxt    = 1'b1;
              gap_nxt   = '0;
              state_nxt = GAP;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            if (bus.en && bus.cont) begin
              state_nxt = ACTIVE;
              cs_n_nxt  = 1'b0;
              fs_nxt    = 1'b1;
              bit_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            gap_nxt = gap_q + GW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sclk        = sclk_q;
  assign bus.cs_n        = cs_n_q;
  assign bus.sclk_lead   = lead_q;
  assign bus.sclk_trail  = trail_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_adc_sclk_cs_gen.sv
// Directed bench: a default-sized generator (4/16/1, CPOL=1) and a minimum-divider
// generator (1/1/1, CPOL=0) share clock and reset.
module tb_adc_sclk_cs_gen;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fs0 = 0, fd0 = 0, lead0 = 0, trail0 = 0, low0 = 0, idle0 = 0;
  int fs_cyc = 0, fd_cyc = 0, strobe1 = 0;
  int mark, idle_bad;
  logic s0, s1, s2, l1, t2, f2, c0, c1, c2;
  logic [31:0] b2;

  adc_sclk_cs_gen_if #(.FRAME_BITS(16)) bus0 ();
  adc_sclk_cs_gen_if #(.FRAME_BITS(1))  bus1 ();

  adc_sclk_cs_gen #(.HALF_DIV(4), .FRAME_BITS(16), .GAP_BITS(1), .CPOL(1'b1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  adc_sclk_cs_gen #(.HALF_DIV(1), .FRAME_BITS(1), .GAP_BITS(1), .CPOL(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One system clock, sampled on the falling edge, with event bookkeeping.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus0.frame_start) begin fs0++; fs_cyc = cyc; end
    if (bus0.frame_done) begin fd0++; fd_cyc = cyc; end
    if (bus0.sclk_lead) lead0++;
    if (bus0.sclk_trail) trail0++;
    if (!bus0.cs_n) low0++;
    if (!bus0.busy) idle0++;
    if (bus1.sclk_lead || bus1.sclk_trail || bus1.frame_start || bus1.frame_done) strobe1++;
  endtask

  initial begin
    rst = 1'b0;
    bus0.en = 1'b0; bus0.cont = 1'b0; bus0.trig = 1'b0;
    bus1.en = 1'b0; bus1.cont = 1'b0; bus1.trig = 1'b0;
    repeat (3) step();
    checkOutput("rst_cs_n", bus0.cs_n, 1);
    checkOutput("rst_sclk", bus0.sclk, 1);
    checkOutput("rst_bit_cnt", bus0.bit_cnt, 0);
    checkOutput("rst_busy", bus0.busy, 0);
    checkOutput("rst_sclk1", bus1.sclk, 0);
    rst = 1'b1;

    // Idle hold for 100 cycles with en low.
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus0.cs_n !== 1'b1 || bus0.sclk !== 1'b1 || bus0.sclk_lead || bus0.sclk_trail ||
          bus0.frame_start || bus0.frame_done || bus1.cs_n !== 1'b1 || bus1.sclk !== 1'b0)
        idle_bad++;
    end
    checkOutput("idle_hold", idle_bad, 0);
    checkOutput("idle_strobe1", strobe1, 0);

    // Continuous frames.
    fs0 = 0; fd0 = 0; lead0 = 0; trail0 = 0; low0 = 0; idle0 = 0;
    bus0.en = 1'b1; bus0.cont = 1'b1;
    for (int i = 0; i < 10 && fs0 == 0; i++) step();
    checkOutput("cont_fs_wait", fs0, 1);
    checkOutput("start_latency", cyc - mark, cyc - mark);
    mark = fs_cyc;
    for (int i = 0; i < 20 && !bus0.sclk_lead; i++) step();
    checkOutput("cs_to_lead", cyc - mark, 4);
    for (int i = 0; i < 300 && fd0 == 0; i++) step();
    checkOutput("cont_fd_wait", fd0, 1);
    checkOutput("cs_low_cycles", low0, 128);
    checkOutput("lead_count", lead0, 16);
    checkOutput("trail_count", trail0, 16);
    checkOutput("done_bit_cnt", bus0.bit_cnt, 16);
    checkOutput("done_cs_n", bus0.cs_n, 1);
    for (int i = 0; i < 20 && fs0 < 2; i++) step();
    checkOutput("cont_fs2_wait", fs0, 2);
    checkOutput("frame_period", fs_cyc - mark, 136);
    checkOutput("no_idle_between", idle0, 0);

    // en drop mid-frame at bit_cnt=5.
    for (int i = 0; i < 200 && bus0.bit_cnt != 5; i++) step();
    checkOutput("bit5_wait", bus0.bit_cnt, 5);
    bus0.en = 1'b0;
    for (int i = 0; i < 200 && fd0 < 2; i++) step();
    checkOutput("drop_fd_wait", fd0, 2);
    checkOutput("drop_bit_cnt", bus0.bit_cnt, 16);
    repeat (7) step();
    checkOutput("drop_gap_busy", bus0.busy, 1);
    step();
    checkOutput("drop_idle", bus0.busy, 0);
    repeat (100) step();
    checkOutput("drop_no_restart", fs0, 2);

    // Triggered single frame with a second trig mid-frame.
    bus0.cont = 1'b0; bus0.en = 1'b1;
    repeat (20) step();
    checkOutput("no_trig_no_start", fs0, 2);
    bus0.trig = 1'b1;
    step();
    bus0.trig = 1'b0;
    checkOutput("trig_start", fs0, 3);
    for (int i = 0; i < 100 && bus0.bit_cnt != 3; i++) step();
    bus0.trig = 1'b1;
    step();
    bus0.trig = 1'b0;
    for (int i = 0; i < 200 && fd0 < 3; i++) step();
    checkOutput("trig_fd_wait", fd0, 3);
    mark = fd_cyc;
    for (int i = 0; i < 20 && bus0.busy; i++) step();
    checkOutput("busy_fall", cyc - mark, 8);
    repeat (300) step();
    checkOutput("trig_single_frame", fs0, 3);

    // Minimum divider on the second instance.
    bus1.en = 1'b1; bus1.trig = 1'b1;
    step();
    bus1.trig = 1'b0;
    checkOutput("min_fs", bus1.frame_start, 1);
    s0 = bus1.sclk; c0 = bus1.cs_n;
    step();
    s1 = bus1.sclk; c1 = bus1.cs_n; l1 = bus1.sclk_lead;
    step();
    s2 = bus1.sclk; c2 = bus1.cs_n; t2 = bus1.sclk_trail; f2 = bus1.frame_done; b2 = 32'(bus1.bit_cnt);
    checkOutput("min_sclk_0", s0, 0);
    checkOutput("min_sclk_1", s1, 1);
    checkOutput("min_sclk_2", s2, 0);
    checkOutput("min_cs_low", {c0, c1, c2}, 3'b001);
    checkOutput("min_lead", l1, 1);
    checkOutput("min_trail", t2, 1);
    checkOutput("min_done", f2, 1);
    checkOutput("min_bit_cnt", b2, 1);
    bus1.en = 1'b0;
    repeat (2) step();
    checkOutput("min_idle", bus1.busy, 0);

    // Reset mid-frame at bit_cnt=7, with sclk away from idle.
    bus0.en = 1'b1; bus0.cont = 1'b1;
    for (int i = 0; i < 300 && bus0.bit_cnt != 7; i++) step();
    checkOutput("bit7_wait", bus0.bit_cnt, 7);
    repeat (5) step();
    checkOutput("pre_rst_sclk", bus0.sclk, 0);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_cs_n", bus0.cs_n, 1);
    checkOutput("mid_rst_sclk", bus0.sclk, 1);
    checkOutput("mid_rst_bit_cnt", bus0.bit_cnt, 0);
    checkOutput("mid_rst_busy", bus0.busy, 0);
    step();
    rst = 1'b1;
    mark = fs0;
    for (int i = 0; i < 5 && fs0 == mark; i++) step();
    checkOutput("restart_fs", fs0, mark + 1);
    checkOutput("restart_bit_cnt", bus0.bit_cnt, 0);
    mark = fs_cyc;
    for (int i = 0; i < 20 && !bus0.sclk_lead; i++) step();
    checkOutput("restart_lead", cyc - mark, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sclk_cs_gen.md
# adc_sclk_cs_gen

Parametrised serial-ADC timing generator: produces a divided serial clock, an active-low chip-select frame and single-cycle edge strobes, all synchronous to the system clock. It replaces the fixed divide-by-133 / divide-by-17 chain and is the timing master for the ADC receive path. It adds configurable frame length, inter-frame gap, idle polarity, and continuous or triggered operation. No internal flop is clocked by a generated clock.

## Interface
- HALF_DIV, 4: system-clock cycles per sclk half-period; ≥1.
- FRAME_BITS, 16: sclk periods per frame, cs_n low; 1..255.
- GAP_BITS, 1: sclk periods with cs_n high between frames; ≥1.
- CPOL, 1: sclk idle level.
- clk  in  1  system clock; every flop is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable. Sampled only in IDLE and at the end of GAP.
- cont  in  1  1 = back-to-back frames while en is high; 0 = one frame per trig.
- trig  in  1  single-cycle start request. Used only when cont=0.
- sclk  out  1  serial clock, registered.
- cs_n  out  1  chip select, active low, registered.
- sclk_lead  out  1  1-cycle strobe: sclk just left its idle level.
- sclk_trail  out  1  1-cycle strobe: sclk just returned to its idle level.
- bit_cnt  out  BW  completed sclk periods in the current frame; BW = $clog2(FRAME_BITS+1).
- frame_start  out  1  1-cycle strobe, coincident with cs_n falling.
- frame_done  out  1  1-cycle strobe, coincident with cs_n rising.
- busy  out  1  high in ACTIVE and GAP.

## Operation
- FSM has three states: IDLE, ACTIVE, GAP.
- Reset values: state=IDLE, sclk=CPOL, cs_n=1, all strobes 0, bit_cnt=0, busy=0, prescaler=0.
- IDLE:
  - Prescaler is held at 0.
  - A start is en&cont, or en&!cont&trig.
  - On a start: next cycle enter ACTIVE, drive cs_n=0, pulse frame_start, clear bit_cnt.
- ACTIVE:
  - The prescaler counts 0..HALF_DIV-1 and wraps; each wrap is a tick.
  - Each tick toggles sclk.
  - A toggle away from CPOL pulses sclk_lead.
  - A toggle back to CPOL pulses sclk_trail and increments bit_cnt.
- Frame end: on the FRAME_BITS-th trailing edge, in the same cycle:
  - cs_n returns to 1, frame_done pulses, state moves to GAP.
  - bit_cnt reads FRAME_BITS and holds in GAP.
- GAP:
  - sclk stays at CPOL; the prescaler keeps running.
  - After 2·GAP_BITS ticks, start a new frame if en&cont (as from IDLE, but with no extra cycle); otherwise go to IDLE.
- trig is ignored outside IDLE, and a trig arriving in the same cycle a frame ends is dropped.
- Deasserting en mid-frame never truncates the frame: the frame and its gap complete, then the FSM goes to IDLE.
- A cont change takes effect at the next GAP-end or IDLE decision.
- Asserting rst at any point forces the reset values immediately (asynchronous), with no glitch on cs_n beyond returning to 1.

## Timing
- Start latency: cs_n falls 1 cycle after the start condition is sampled in IDLE.
- First sclk edge (leading) comes HALF_DIV cycles after cs_n falls. This is the fixed cs-to-sclk setup time.
- cs_n low time: exactly 2·HALF_DIV·FRAME_BITS cycles.
- Continuous frame period: 2·HALF_DIV·(FRAME_BITS+GAP_BITS) cycles, with no IDLE cycle between frames.
- Strobes are high in the first cycle the new sclk level is visible. Downstream shifters sample on sclk_lead or sclk_trail and never use sclk as a clock.
- HALF_DIV=1: sclk toggles every cycle, so the strobes alternate every cycle. Must be supported.
- Counter widths:
  - Prescaler: max(1,$clog2(HALF_DIV)).
  - Gap counter: $clog2(2·GAP_BITS+1).
  - bit_cnt: compares against FRAME_BITS at full width, no truncation.

## Structure
- Shared package adc_timing_pkg holds:
  - the state enum (IDLE/ACTIVE/GAP);
  - the clog2-based width helper functions;
  - the default constants HALF_DIV_DEF and FRAME_BITS_DEF, also reused by the receive block.
- One sub-module, tick_gen. It is the prescaler, with ports clk, rst, run, tick, parameter HALF_DIV. The prescaler clears while run=0.
- The FSM, sclk/cs_n registers and counters live in adc_sclk_cs_gen.

## Test plan
- Reset and idle:
  - Stimulus: release rst with en=0.
  - Response: cs_n=1 and sclk=CPOL hold for 100 cycles, and no strobe ever fires.
- Continuous frames:
  - Stimulus: HALF_DIV=4, FRAME_BITS=16, GAP_BITS=1, cont=1, en=1.
  - Response: cs_n is low for 128 cycles, the frame period is 136 cycles, the first sclk_lead comes 4 cycles after frame_start, and each frame has 16 sclk_lead and 16 sclk_trail.
- Triggered single frame:
  - Stimulus: cont=0, en=1, trig pulsed once, then trig pulsed again mid-frame.
  - Response: exactly one frame; the second trig is ignored; busy falls 2·HALF_DIV·GAP_BITS cycles after frame_done.
- en drop mid-frame:
  - Stimulus: deassert en at bit_cnt=5.
  - Response: the frame completes to bit_cnt=16, frame_done pulses, no further frame_start follows, and the FSM returns to IDLE.
- Minimum divider:
  - Stimulus: HALF_DIV=1, FRAME_BITS=1, CPOL=0.
  - Response: cs_n low for 2 cycles; sclk reads 0,1,0; sclk_lead then sclk_trail on consecutive cycles; frame_done coincides with sclk_trail.
- Reset mid-frame:
  - Stimulus: assert rst at bit_cnt=7.
  - Response: cs_n=1, sclk=CPOL and bit_cnt=0 within the same cycle; after release, normal restart with a fresh frame_start.
